// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle main FSM and the datapath/memory side.
// The master modport is the FSM; the slave modport is whoever consumes its enables.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegWrite;
    logic       RegDst;
    logic       ALUSrcA;
    logic       zext;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [2:0] aluop;
    logic [3:0] state;
    logic       inst_done;
    logic       illegal;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, RegDst, ALUSrcA, zext,
               PCSource, ALUSrcB, aluop, state, inst_done, illegal
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, RegDst, ALUSrcA, zext,
               PCSource, ALUSrcB, aluop, state, inst_done, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle CPU: sequences datapath enables over 3-5
// cycles per instruction, stalls on mem_ready, and drives aluop to the ALU decoder.
module multicycle_control (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_if.master        bus
);

    typedef enum logic [3:0] {
        ST_RST = 4'd0,
        ST_IF  = 4'd1,
        ST_ID  = 4'd2,
        ST_ADR = 4'd3,
        ST_MRD = 4'd4,
        ST_MWB = 4'd5,
        ST_MWR = 4'd6,
        ST_REX = 4'd7,
        ST_RWB = 4'd8,
        ST_BEQ = 4'd9,
        ST_JMP = 4'd10,
        ST_IEX = 4'd11,
        ST_IWB = 4'd12,
        ST_ILL = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;

    // op_q latches the opcode only on the edge leaving ID so later states ignore IR churn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_ID) begin
                op_q <= bus.opcode;
            end
        end
    end

    always_comb begin
        state_d = ST_IF;
        case (state_q)
            ST_RST: state_d = ST_IF;
            ST_IF:  state_d = bus.mem_ready ? ST_ID : ST_IF;
            ST_ID: begin
                case (bus.opcode)
                    OP_LW, OP_SW:                     state_d = ST_ADR;
                    OP_RTYPE:                         state_d = ST_REX;
                    OP_BEQ:                           state_d = ST_BEQ;
                    OP_J:                             state_d = ST_JMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = ST_IEX;
                    default:                          state_d = ST_ILL;
                endcase
            end
            ST_ADR: state_d = (op_q == OP_LW) ? ST_MRD : ST_MWR;
            ST_MRD: state_d = bus.mem_ready ? ST_MWB : ST_MRD;
            ST_MWB: state_d = ST_IF;
            ST_MWR: state_d = bus.mem_ready ? ST_IF : ST_MWR;
            ST_REX: state_d = ST_RWB;
            ST_RWB: state_d = ST_IF;
            ST_BEQ: state_d = ST_IF;
            ST_JMP: state_d = ST_IF;
            ST_IEX: state_d = ST_IWB;
            ST_IWB: state_d = ST_IF;
            ST_ILL: state_d = ST_IF;
            default: state_d = ST_IF;
        endcase
    end

    // Everything defaults low so reset and the unused codes 14/15 drive no enables.
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.zext        = 1'b0;
        bus.PCSource    = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.aluop       = 3'b000;
        bus.inst_done   = 1'b0;
        bus.illegal     = 1'b0;
        case (state_q)
            ST_IF: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            ST_ID: begin
                bus.ALUSrcB = 2'b11;
            end
            ST_ADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            ST_MRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            ST_MWB: begin
                bus.RegWrite  = 1'b1;
                bus.MemtoReg  = 1'b1;
                bus.inst_done = 1'b1;
            end
            ST_MWR: begin
                bus.MemWrite  = 1'b1;
                bus.IorD      = 1'b1;
                bus.inst_done = bus.mem_ready;
            end
            ST_REX: begin
                bus.ALUSrcA = 1'b1;
                bus.aluop   = 3'b010;
            end
            ST_RWB: begin
                bus.RegWrite  = 1'b1;
                bus.RegDst    = 1'b1;
                bus.inst_done = 1'b1;
            end
            ST_BEQ: begin
                bus.ALUSrcA     = 1'b1;
                bus.aluop       = 3'b001;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.inst_done   = 1'b1;
            end
            ST_JMP: begin
                bus.PCWrite   = 1'b1;
                bus.PCSource  = 2'b10;
                bus.inst_done = 1'b1;
            end
            ST_IEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                case (op_q)
                    OP_ANDI: begin
                        bus.aluop = 3'b011;
                        bus.zext  = 1'b1;
                    end
                    OP_ORI: begin
                        bus.aluop = 3'b100;
                        bus.zext  = 1'b1;
                    end
                    OP_SLTI: bus.aluop = 3'b101;
                    default: bus.aluop = 3'b000;
                endcase
            end
            ST_IWB: begin
                bus.RegWrite  = 1'b1;
                bus.inst_done = 1'b1;
            end
            ST_ILL: begin
                bus.illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction phase model pushes
// the expected outputs of every cycle, and a negedge monitor compares them.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] state;
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regWrite;
        logic       regDst;
        logic       aluSrcA;
        logic       zext;
        logic [1:0] pcSource;
        logic [1:0] aluSrcB;
        logic [2:0] aluop;
        logic       instDone;
        logic       illegal;
    } outVec_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   junkOpcode;

    outVec_t expQ[$];
    string   tagQ[$];
    logic [5:0] legalOps[9];

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs of one cycle spent in a given phase of an instruction.
    function automatic outVec_t expOut(input int ph, input logic [5:0] op, input logic mr);
        outVec_t o;
        o = '0;
        o.state = 4'(ph);
        case (ph)
            1: begin
                o.memRead = 1'b1; o.aluSrcB = 2'b01; o.irWrite = mr; o.pcWrite = mr;
            end
            2: o.aluSrcB = 2'b11;
            3: begin o.aluSrcA = 1'b1; o.aluSrcB = 2'b10; end
            4: begin o.memRead = 1'b1; o.iorD = 1'b1; end
            5: begin o.regWrite = 1'b1; o.memtoReg = 1'b1; o.instDone = 1'b1; end
            6: begin o.memWrite = 1'b1; o.iorD = 1'b1; o.instDone = mr; end
            7: begin o.aluSrcA = 1'b1; o.aluop = 3'b010; end
            8: begin o.regWrite = 1'b1; o.regDst = 1'b1; o.instDone = 1'b1; end
            9: begin
                o.aluSrcA = 1'b1; o.aluop = 3'b001; o.pcWriteCond = 1'b1;
                o.pcSource = 2'b01; o.instDone = 1'b1;
            end
            10: begin o.pcWrite = 1'b1; o.pcSource = 2'b10; o.instDone = 1'b1; end
            11: begin
                o.aluSrcA = 1'b1; o.aluSrcB = 2'b10;
                if (op == OP_ANDI) begin o.aluop = 3'b011; o.zext = 1'b1; end
                else if (op == OP_ORI) begin o.aluop = 3'b100; o.zext = 1'b1; end
                else if (op == OP_SLTI) o.aluop = 3'b101;
            end
            12: begin o.regWrite = 1'b1; o.instDone = 1'b1; end
            13: o.illegal = 1'b1;
            default: begin end
        endcase
        return o;
    endfunction

    // One clock cycle: drive inputs just after the edge and record what must appear.
    task automatic applyStimulus(input int ph, input logic [5:0] op, input logic mr);
        @(posedge clk);
        #1;
        bus.mem_ready = mr;
        if (ph == 2) bus.opcode = op;
        else if (junkOpcode >= 0) bus.opcode = 6'(junkOpcode);
        else bus.opcode = 6'($urandom);
        expQ.push_back(expOut(ph, op, mr));
        tagQ.push_back($sformatf("op=%b ph=%0d mr=%0b", op, ph, mr));
    endtask

    task automatic checkOutput();
        outVec_t got;
        outVec_t want;
        string   tag;
        if (expQ.size() != 0) begin
            want = expQ.pop_front();
            tag  = tagQ.pop_front();
            got  = {bus.state, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                    bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegWrite, bus.RegDst,
                    bus.ALUSrcA, bus.zext, bus.PCSource, bus.ALUSrcB, bus.aluop,
                    bus.inst_done, bus.illegal};
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL %s: got=%h want=%h (state got %0d want %0d)",
                         tag, got, want, got.state, want.state);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            checkOutput();
        end
    end

    task automatic resetCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            bus.mem_ready = 1'(($urandom));
            expQ.push_back(expOut(0, 6'd0, 1'b0));
            tagQ.push_back("reset held");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expQ.push_back(expOut(0, 6'd0, 1'b0));
        tagQ.push_back("reset released");
    endtask

    // Number of not-ready cycles before a memory phase completes.
    function automatic int pickStalls(input int forced);
        int n;
        if (forced >= 0) return forced;
        n = 0;
        while (n < 3 && $urandom_range(0, 99) < 30) n++;
        return n;
    endfunction

    // Whole instruction: phase list derived from the opcode class, stalls inserted on memory phases.
    task automatic runInstr(input logic [5:0] op, input int ifStalls, input int memStalls);
        int phases[$];
        phases.push_back(1);
        phases.push_back(2);
        case (op)
            OP_LW: begin phases.push_back(3); phases.push_back(4); phases.push_back(5); end
            OP_SW: begin phases.push_back(3); phases.push_back(6); end
            OP_RTYPE: begin phases.push_back(7); phases.push_back(8); end
            OP_BEQ: phases.push_back(9);
            OP_J: phases.push_back(10);
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin phases.push_back(11); phases.push_back(12); end
            default: phases.push_back(13);
        endcase
        foreach (phases[i]) begin
            if (phases[i] == 1 || phases[i] == 4 || phases[i] == 6) begin
                repeat (pickStalls(phases[i] == 1 ? ifStalls : memStalls))
                    applyStimulus(phases[i], op, 1'b0);
                applyStimulus(phases[i], op, 1'b1);
            end else begin
                applyStimulus(phases[i], op, 1'(($urandom)));
            end
        end
    endtask

    initial begin
        logic [5:0] op;
        int r;
        errors = 0;
        checks = 0;
        junkOpcode = -1;
        legalOps = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
        rst_n = 1'b0;
        bus.opcode = 6'd0;
        bus.mem_ready = 1'b0;

        resetCycles(3);
        runInstr(OP_LW, 3, 0);
        runInstr(OP_LW, 0, 0);
        junkOpcode = 0;
        runInstr(OP_SW, 0, 1);
        junkOpcode = -1;
        runInstr(OP_RTYPE, 0, 0);
        runInstr(OP_BEQ, 0, 0);
        runInstr(OP_J, 0, 0);
        runInstr(OP_ANDI, 0, 0);
        runInstr(OP_ORI, 0, 0);
        runInstr(OP_SLTI, 0, 0);
        runInstr(OP_ADDI, 0, 0);
        runInstr(6'b111111, 0, 0);

        // Reset dropped while a store is waiting on memory.
        applyStimulus(1, OP_SW, 1'b1);
        applyStimulus(2, OP_SW, 1'b1);
        applyStimulus(3, OP_SW, 1'b0);
        applyStimulus(6, OP_SW, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        expQ.push_back(expOut(0, 6'd0, 1'b0));
        tagQ.push_back("reset mid-MWR");
        resetCycles(1);

        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (r < 9) op = legalOps[r];
            else op = 6'($urandom);
            runInstr(op, -1, -1);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle variant of the CPU. It sits directly upstream of the ALU control decoder and produces the 3-bit `aluop` that the decoder combines with `funct`. It also sequences every datapath enable (PC, IR, memory, register file, mux selects) over 3-5 cycles per instruction and stalls on a memory-ready handshake.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `opcode`  in  6  — instr[31:26] from the IR; valid from the ID state onward.
- `mem_ready`  in  1  — memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegWrite`, `RegDst`, `ALUSrcA`, `zext`  out  1 each  — datapath enables and selects.
- `PCSource`  out  2  — PC mux select: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump address.
- `ALUSrcB`  out  2  — 00 = B, 01 = constant 4, 10 = immediate, 11 = immediate<<2.
- `aluop`  out  3  — to the ALU control decoder: 000 add, 001 sub, 010 R-type (decode `funct`), 011 and, 100 or, 101 slt.
- `state`  out  4  — current state code, for debug and verification.
- `inst_done`  out  1  — high in the final cycle of each retired instruction.
- `illegal`  out  1  — one-cycle pulse on an unsupported opcode.

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
  - andi 001100
  - ori 001101
  - slti 001010
- `op_q` (6-bit register) captures `opcode` on the clock edge that leaves ID. All later decisions use `op_q`, not `opcode`.
- State codes, outputs, and transitions. Any output not listed is 0 in that state.
  - RST (0): all outputs 0. Always goes to IF.
  - IF (1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, aluop=000, PCSource=00, IRWrite=PCWrite=`mem_ready`. Goes to ID if `mem_ready`, else stays in IF.
  - ID (2): ALUSrcA=0, ALUSrcB=11, aluop=000. Next state by `opcode`:
    - lw or sw → ADR
    - R-type → REX
    - beq → BEQ
    - j → JMP
    - addi, andi, ori, slti → IEX
    - anything else → ILL
  - ADR (3): ALUSrcA=1, ALUSrcB=10, aluop=000. Goes to MRD if `op_q` is lw, else MWR.
  - MRD (4): MemRead=1, IorD=1. Goes to MWB if `mem_ready`, else stays.
  - MWB (5): RegWrite=1, MemtoReg=1, RegDst=0, inst_done=1. Goes to IF.
  - MWR (6): MemWrite=1, IorD=1, inst_done=`mem_ready`. Goes to IF if `mem_ready`, else stays.
  - REX (7): ALUSrcA=1, ALUSrcB=00, aluop=010. Goes to RWB.
  - RWB (8): RegWrite=1, RegDst=1, MemtoReg=0, inst_done=1. Goes to IF.
  - BEQ (9): ALUSrcA=1, ALUSrcB=00, aluop=001, PCWriteCond=1, PCSource=01, inst_done=1. Goes to IF.
  - JMP (10): PCWrite=1, PCSource=10, inst_done=1. Goes to IF.
  - IEX (11): ALUSrcA=1, ALUSrcB=10. aluop and zext by `op_q`:
    - addi: aluop=000, zext=0
    - andi: aluop=011, zext=1
    - ori: aluop=100, zext=1
    - slti: aluop=101, zext=0
    - Goes to IWB.
  - IWB (12): RegWrite=1, RegDst=0, MemtoReg=0, inst_done=1. Goes to IF.
  - ILL (13): illegal=1. Goes to IF. No architectural write occurs; the PC was already advanced in IF.
- State codes 14 and 15 are unreachable. If entered, the next state is IF and all outputs are 0.
- Outputs are a combinational decode of `state`, with `op_q` for IEX and `mem_ready` where noted. The state register and `op_q` are the only flops.

## Timing
- Reset:
  - While `rst_n` is low: state=RST, `op_q`=0, all outputs 0.
  - Assertion takes effect immediately, including mid-instruction or mid-wait. No memory or register write enable can remain high.
  - The first rising edge after `rst_n` goes high moves RST → IF.
- Cycle counts with `mem_ready` held at 1:
  - lw: 5 (IF, ID, ADR, MRD, MWB)
  - sw: 4
  - R-type: 4
  - I-type ALU: 4
  - beq: 3
  - j: 3
  - illegal opcode: 3
- Each cycle in which IF, MRD, or MWR sees `mem_ready`=0 adds exactly one cycle. During that wait:
  - MemRead or MemWrite stays asserted.
  - IRWrite and PCWrite stay at 0.
  - All other outputs are held at that state's values.
- `inst_done` is high for exactly one cycle per instruction, and is never high in IF or ID.
- `opcode` may change after the edge that leaves ID without affecting ADR or IEX decoding.

## Test plan
- Reset and wait: hold `rst_n`=0 → state=0, all outputs 0. Release, then hold `mem_ready`=0 for 3 cycles → state stays 1 with MemRead=1, IRWrite=0, PCWrite=0. Raise `mem_ready` → IRWrite=PCWrite=1 in that cycle, then ID.
- lw (100011) with `mem_ready`=1 → states 1,2,3,4,5. aluop=000 in ADR. MWB has RegWrite=1, MemtoReg=1, inst_done=1, so inst_done rises on the 5th cycle.
- sw (101011), then `opcode` changed to 000000 after ID, with one `mem_ready`=0 cycle in MWR → MWR entered (not MRD). MemWrite=1 for 2 cycles; inst_done only on the second.
- R-type, then beq, then j → REX has aluop=010. BEQ has aluop=001, PCWriteCond=1, PCSource=01. JMP has PCWrite=1, PCSource=10. Lengths 4, 3, 3 cycles.
- andi, ori, slti, addi → aluop and zext in IEX are 011/1, 100/1, 101/0, 000/0 respectively. IWB has RegWrite=1, RegDst=0.
- Opcode 111111 → illegal=1 in cycle 3 with no enables, then IF. Separately, assert `rst_n`=0 mid-MWR → MemWrite drops to 0 immediately and state=0.
